// File: rtl/prng_arbiter_if.sv
// prng_arbiter_if
//   Request/grant bundle between game requesters and the PRNG arbiter.
//   req     : per-requester request level
//   bound   : per-requester exclusive upper bound, slice i = [i*RW +: RW]
//   ack     : one-cycle, one-hot grant pulse
//   rnd_out : drawn value, valid only while ack is high (0 otherwise)
//   busy    : arbiter is serving a request
//   master modport = requester side, slave modport = arbiter side.
interface prng_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int RW      = 16
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*RW-1:0] bound;
  logic [NUM_REQ-1:0]    ack;
  logic [RW-1:0]         rnd_out;
  logic                  busy;

  modport master (output req, output bound, input ack, input rnd_out, input busy);
  modport slave  (input req, input bound, output ack, output rnd_out, output busy);
endinterface

// File: rtl/prng_arbiter.sv
// prng_arbiter
//   Shares one free-running 32-bit PRNG between NUM_REQ requesters. Each grant
//   returns a value in [0, bound) drawn by masked rejection sampling with at most
//   MAX_TRIES attempts; after the last reject the value is folded as c - b.
//   Round-robin arbitration. The block also raises the PRNG enable after reset.
// Ports
//   clk       : system clock
//   reset     : synchronous, active-low reset
//   prng_en   : PRNG enable, high from the first edge after reset release
//   prng_data : PRNG word, fresh every cycle; only [RW-1:0] is used
//   bus       : slave side of prng_arbiter_if (req, bound, ack, rnd_out, busy)
module prng_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RW        = 16,
  parameter int MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             prng_en,
  input  logic [31:0]      prng_data,
  prng_arbiter_if.slave    bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] pick_id;
  logic          pick_vld;
  logic [TW-1:0] tries;
  logic [RW-1:0] b;
  logic [RW-1:0] mask;
  logic [RW-1:0] res;
  logic [RW-1:0] cand;
  logic [RW-1:0] gnt_bound;
  logic          unused_prng;

  // Smallest 2^k-1 covering b-1; smearing the top set bit downwards gives it.
  function automatic logic [RW-1:0] fill_mask(input logic [RW-1:0] bnd);
    logic [RW-1:0] m;
    m = bnd - RW'(1);
    for (int i = 0; i < RW; i++) m = m | (m >> 1);
    if (bnd <= RW'(1)) m = '0;
    return m;
  endfunction

  // Since mask < 2b, a rejected candidate folds into range by one subtraction.
  function automatic logic [RW-1:0] fold(input logic [RW-1:0] c, input logic [RW-1:0] bnd);
    return (c < bnd) ? c : (c - bnd);
  endfunction

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int j;
    j = int'(base) + off;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return IW'(j);
  endfunction

  assign unused_prng = ^prng_data[31:RW];
  assign gnt_bound   = bus.bound[gnt_id*RW +: RW];
  assign cand        = prng_data[RW-1:0] & mask;

  // Round-robin pick: the lowest offset from rr_ptr wins, so scan high to low.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[rr_idx(rr_ptr, i)]) begin
        pick_vld = 1'b1;
        pick_id  = rr_idx(rr_ptr, i);
      end
    end
  end

  // Control: FSM, round-robin pointer, retry counter, PRNG enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_id  <= '0;
      tries   <= '0;
      prng_en <= 1'b0;
    end else begin
      prng_en <= 1'b1;
      case (state)
        IDLE: begin
          if (prng_en && pick_vld) begin
            gnt_id <= pick_id;
            state  <= GRANT;
          end
        end
        GRANT: begin
          tries <= '0;
          state <= (gnt_bound <= RW'(1)) ? DONE : DRAW;
        end
        DRAW: begin
          if (cand < b || tries == TW'(MAX_TRIES - 1)) state <= DONE;
          else tries <= tries + TW'(1);
        end
        DONE: begin
          rr_ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: bound/mask latched in GRANT, result refreshed every DRAW cycle
  always_ff @(posedge clk) begin
    if (state == GRANT) begin
      b    <= gnt_bound;
      mask <= fill_mask(gnt_bound);
      res  <= '0;
    end else if (state == DRAW) begin
      res  <= fold(cand, b);
    end
  end

  // Outputs: result is presented only in DONE
  always_comb begin
    bus.ack     = '0;
    bus.rnd_out = '0;
    if (state == DONE) begin
      bus.ack[gnt_id] = 1'b1;
      bus.rnd_out     = res;
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter
//   Directed scenarios plus randomized traffic for prng_arbiter, checked against
//   a behavioural model (round-robin pick, rejection sampling over the recorded
//   PRNG word stream).
module tb_prng_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int RW        = 16;
  localparam int MAX_TRIES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prng_en;
  logic [31:0] prng_data = 32'h0;

  prng_arbiter_if #(.NUM_REQ(NUM_REQ), .RW(RW)) bus();

  prng_arbiter #(.NUM_REQ(NUM_REQ), .RW(RW), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk),
    .reset(reset),
    .prng_en(prng_en),
    .prng_data(prng_data),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          m_rr = 0;
  logic [31:0] hist [int];
  logic [31:0] pq [$];

  // Advance one cycle; the new PRNG word belongs to the period after this edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pq.size() > 0) prng_data = pq.pop_front();
    else prng_data = $urandom;
    hist[cyc] = prng_data;
  endtask

  task automatic set_bound(input int i, input logic [RW-1:0] v);
    bus.bound[i*RW +: RW] = v;
  endtask

  task automatic wait_ack(input bit clr, output int d, output logic [NUM_REQ-1:0] a,
                          output logic [RW-1:0] r);
    d = -1; a = '0; r = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.ack != '0) begin
        d = cyc; a = bus.ack; r = bus.rnd_out;
        if (clr) bus.req = '0;
        break;
      end
    end
  endtask

  // Reference: expected value and latency from req period p, using recorded words.
  function automatic void model(input logic [RW-1:0] bnd, input int p,
                                output logic [RW-1:0] r, output int lat);
    int mk;
    int c;
    r = '0; lat = 2;
    if (bnd <= 1) return;
    mk = 0;
    while (mk < int'(bnd) - 1) mk = mk * 2 + 1;
    for (int t = 0; t < MAX_TRIES; t++) begin
      c = int'(hist[p + 2 + t][RW-1:0]) & mk;
      if (c < int'(bnd)) begin
        r = RW'(c); lat = 3 + t; return;
      end
      if (t == MAX_TRIES - 1) begin
        r = RW'(c - int'(bnd)); lat = 2 + MAX_TRIES;
      end
    end
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] rq);
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (m_rr + k) % NUM_REQ;
      if (rq[j]) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus.req = '0;
    repeat (3) tick();
    reset = 1'b1;
    m_rr = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = '0;
    bus.bound = '0;
    repeat (3) tick();
    n_total++; if (bus.ack !== '0) $display("FAIL reset_ack got %b exp 0", bus.ack); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
    n_total++; if (prng_en !== 1'b0) $display("FAIL reset_prng_en got %b exp 0", prng_en); else n_pass++;
    n_total++; if (bus.rnd_out !== '0) $display("FAIL reset_rnd got %0d exp 0", bus.rnd_out); else n_pass++;
    reset = 1'b1;
    m_rr = 0;
    #1;
    n_total++; if (prng_en !== 1'b0) $display("FAIL prng_en_early got %b exp 0", prng_en); else n_pass++;
    tick();
    n_total++; if (prng_en !== 1'b1) $display("FAIL prng_en_rise got %b exp 1", prng_en); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++; if (prng_en !== 1'b1) $display("FAIL prng_en_hold got %b exp 1", prng_en); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", bus.busy); else n_pass++;
    end
  endtask

  task automatic test_accept();
    int p, d; logic [NUM_REQ-1:0] a; logic [RW-1:0] r;
    tick();
    p = cyc;
    set_bound(0, 16'd10);
    bus.req = 4'b0001;
    pq = '{$urandom, 32'hBEEF0007};
    wait_ack(1'b1, d, a, r);
    n_total++; if (a !== 4'b0001) $display("FAIL accept_ack got %b exp 0001", a); else n_pass++;
    n_total++; if (r !== 16'd7) $display("FAIL accept_rnd got %0d exp 7", r); else n_pass++;
    n_total++; if (d - p !== 3) $display("FAIL accept_latency got %0d exp 3", d - p); else n_pass++;
    m_rr = 1;
  endtask

  task automatic test_reject();
    int p, d; logic [NUM_REQ-1:0] a; logic [RW-1:0] r;
    tick();
    p = cyc;
    set_bound(1, 16'd5);
    bus.req = 4'b0010;
    pq = '{$urandom, 32'h12340006, 32'hFFF00007, 32'h00A50003};
    wait_ack(1'b1, d, a, r);
    n_total++; if (a !== 4'b0010) $display("FAIL reject_ack got %b exp 0010", a); else n_pass++;
    n_total++; if (r !== 16'd3) $display("FAIL reject_rnd got %0d exp 3", r); else n_pass++;
    n_total++; if (d - p !== 5) $display("FAIL reject_latency got %0d exp 5", d - p); else n_pass++;
    m_rr = 2;
  endtask

  task automatic test_fallback();
    int p, d; logic [NUM_REQ-1:0] a; logic [RW-1:0] r;
    tick();
    p = cyc;
    set_bound(2, 16'd5);
    bus.req = 4'b0100;
    pq = '{$urandom, 32'h00000007, 32'h11110007, 32'h22220007, 32'h33330007};
    repeat (3) tick();
    n_total++; if (bus.busy !== 1'b1) $display("FAIL fallback_busy got %b exp 1", bus.busy); else n_pass++;
    n_total++; if (bus.ack !== '0) $display("FAIL fallback_early_ack got %b exp 0", bus.ack); else n_pass++;
    wait_ack(1'b1, d, a, r);
    n_total++; if (a !== 4'b0100) $display("FAIL fallback_ack got %b exp 0100", a); else n_pass++;
    n_total++; if (r !== 16'd2) $display("FAIL fallback_rnd got %0d exp 2", r); else n_pass++;
    n_total++; if (d - p !== 6) $display("FAIL fallback_latency got %0d exp 6", d - p); else n_pass++;
    m_rr = 3;
  endtask

  task automatic test_back_to_back();
    int p, d, prev; logic [NUM_REQ-1:0] a, ea; logic [RW-1:0] r;
    do_reset();
    tick();
    for (int i = 0; i < NUM_REQ; i++) set_bound(i, '0);
    bus.req = 4'b1111;
    p = cyc;
    prev = p;
    for (int k = 0; k < 5; k++) begin
      wait_ack(1'b0, d, a, r);
      ea = NUM_REQ'(1) << (k % NUM_REQ);
      n_total++; if (a !== ea) $display("FAIL rr_order[%0d] got %b exp %b", k, a, ea); else n_pass++;
      n_total++; if (r !== '0) $display("FAIL rr_rnd[%0d] got %0d exp 0", k, r); else n_pass++;
      n_total++; if (d - prev !== ((k == 0) ? 2 : 3))
        $display("FAIL rr_spacing[%0d] got %0d exp %0d", k, d - prev, (k == 0) ? 2 : 3); else n_pass++;
      prev = d;
    end
    bus.req = '0;
    m_rr = 1;
  endtask

  task automatic test_reset_abort();
    int d; logic [NUM_REQ-1:0] a; logic [RW-1:0] r;
    tick();
    set_bound(2, '0);
    bus.req = 4'b0100;
    wait_ack(1'b1, d, a, r);
    n_total++; if (a !== 4'b0100) $display("FAIL abort_pre_ack got %b exp 0100", a); else n_pass++;
    tick();
    set_bound(0, 16'd5);
    bus.req = 4'b0001;
    pq = '{$urandom, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7};
    repeat (3) tick();
    n_total++; if (bus.busy !== 1'b1) $display("FAIL abort_in_draw got %b exp 1", bus.busy); else n_pass++;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++; if (bus.ack !== '0) $display("FAIL abort_ack[%0d] got %b exp 0", k, bus.ack); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy[%0d] got %b exp 0", k, bus.busy); else n_pass++;
    end
    bus.req = '0;
    pq.delete();
    reset = 1'b1;
    m_rr = 0;
    tick();
    n_total++; if (bus.ack !== '0) $display("FAIL abort_release_ack got %b exp 0", bus.ack); else n_pass++;
    set_bound(0, '0);
    set_bound(3, '0);
    bus.req = 4'b1001;
    wait_ack(1'b1, d, a, r);
    n_total++; if (a !== 4'b0001) $display("FAIL abort_rr_reset got %b exp 0001", a); else n_pass++;
    m_rr = 1;
  endtask

  task automatic test_random();
    int p, d, id, lat; logic [NUM_REQ-1:0] a, rq, ea; logic [RW-1:0] r, er;
    logic [RW-1:0] bnds [NUM_REQ];
    for (int it = 0; it < 150; it++) begin
      tick();
      p = cyc;
      rq = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        case ($urandom_range(0, 5))
          0: bnds[i] = 16'd0;
          1: bnds[i] = 16'd1;
          2: bnds[i] = 16'hFFFF;
          3: bnds[i] = RW'($urandom_range(2, 20));
          4: bnds[i] = 16'h8001;
          default: bnds[i] = RW'($urandom);
        endcase
        set_bound(i, bnds[i]);
      end
      bus.req = rq;
      id = pick(rq);
      ea = NUM_REQ'(1) << id;
      wait_ack(1'b1, d, a, r);
      model(bnds[id], p, er, lat);
      n_total++; if (a !== ea) $display("FAIL rand_ack[%0d] got %b exp %b", it, a, ea); else n_pass++;
      n_total++; if (r !== er) $display("FAIL rand_rnd[%0d] got %0d exp %0d", it, r, er); else n_pass++;
      n_total++; if (d - p !== lat) $display("FAIL rand_latency[%0d] got %0d exp %0d", it, d - p, lat); else n_pass++;
      m_rr = (id + 1) % NUM_REQ;
    end
  endtask

  initial begin
    bus.req = '0;
    bus.bound = '0;
    hist[0] = prng_data;
    test_reset();
    test_accept();
    test_reject();
    test_fallback();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
